// File: rtl/ex_mem_stage.sv
// Execute-to-memory pipeline register with a 2-entry skid buffer and branch resolution.
// Optional stall counter enabled by defining EX_MEM_STALL_CNT_EN.
module ex_mem_stage #(
    parameter int N          = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          alu_result,
    input  logic [3:0]            alu_status,
    input  logic [N-1:0]          store_data,
    input  logic [N-1:0]          branch_target,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  reg_write,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  branch,
    input  logic                  jump,
    input  logic [2:0]            funct3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N-1:0]          out_result,
    output logic [N-1:0]          out_store_data,
    output logic [N-1:0]          out_target,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic [2:0]            out_funct3,
    output logic                  out_taken
`ifdef EX_MEM_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    typedef struct packed {
        logic [N-1:0]          result;
        logic [N-1:0]          store_data;
        logic [N-1:0]          target;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic [2:0]            funct3;
        logic                  taken;
    } entry_t;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   cond;
    logic   accept;
    logic   drain;

    // Status layout is {n, z, c, v}; c is the unsigned borrow of the compare subtraction.
    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:  cond = alu_status[2];
            3'b001:  cond = ~alu_status[2];
            3'b100:  cond = alu_status[3] ^ alu_status[0];
            3'b101:  cond = ~(alu_status[3] ^ alu_status[0]);
            3'b110:  cond = alu_status[1];
            3'b111:  cond = ~alu_status[1];
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        in_entry.result     = alu_result;
        in_entry.store_data = store_data;
        in_entry.target     = branch_target;
        in_entry.rd         = rd;
        in_entry.reg_write  = reg_write;
        in_entry.mem_read   = mem_read;
        in_entry.mem_write  = mem_write;
        in_entry.funct3     = funct3;
        in_entry.taken      = jump | (branch & cond);
    end

    assign accept = in_valid & ~skid_valid_q;
    assign drain  = main_valid_q & out_ready;

    // The skid entry only exists while main is held, so FIFO order is main then skid.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (drain) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q || drain) begin
                main_d       = in_entry;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = in_entry;
                skid_valid_d = 1'b1;
            end
        end else if (drain) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign in_ready       = ~skid_valid_q;
    assign out_valid      = main_valid_q;
    assign out_result     = main_q.result;
    assign out_store_data = main_q.store_data;
    assign out_target     = main_q.target;
    assign out_rd         = main_q.rd;
    assign out_funct3     = main_q.funct3;
    assign out_reg_write  = main_q.reg_write & main_valid_q;
    assign out_mem_read   = main_q.mem_read  & main_valid_q;
    assign out_mem_write  = main_q.mem_write & main_valid_q;
    assign out_taken      = main_q.taken     & main_valid_q;

`ifdef EX_MEM_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute-to-memory pipeline stage directly downstream of the ALU.
- Registers the ALU result, the 4-bit ALU status {n,z,c,v} and the instruction control fields.
- Resolves the branch condition from the status flags.
- Uses a valid/ready handshake with a 2-entry skid buffer, so the memory stage can stall without a combinational ready path back into execute.

Parameters:
- N, 32, datapath width; equals the ALU width.
- REG_ADDR_W, 5, destination register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous reset, active-low.
- flush  in  1  synchronous kill of all held and incoming entries.
- in_valid  in  1  execute presents an entry.
- in_ready  out  1  stage can accept; registered, equals !skid_valid.
- alu_result  in  N  ALU result.
- alu_status  in  4  ALU {n,z,c,v}.
- store_data  in  N  rs2 value for stores.
- branch_target  in  N  computed target PC.
- rd  in  REG_ADDR_W  destination register.
- reg_write  in  1  writeback enable.
- mem_read  in  1  load.
- mem_write  in  1  store.
- branch  in  1  conditional branch.
- jump  in  1  unconditional jump.
- funct3  in  3  branch/memory funct3.
- out_valid  out  1  entry available to memory stage.
- out_ready  in  1  memory stage accepts.
- out_result, out_store_data, out_target  out  N each  registered copies.
- out_rd  out  REG_ADDR_W  registered copy.
- out_reg_write, out_mem_read, out_mem_write  out  1 each  registered copies.
- out_funct3  out  3  registered copy.
- out_taken  out  1  registered branch/jump decision.

Behaviour:
- Reset (rstn=0, asynchronous): main_valid=0, skid_valid=0, so out_valid=0 and in_ready=1.
  - All data outputs are 0.
  - out_taken, out_reg_write, out_mem_read and out_mem_write are 0.
  - Deassertion is synchronous to clk via the caller's reset synchroniser.
- Taken decision, computed combinationally at the input and stored with the entry: taken = jump | (branch & cond(funct3)).
  - 000 → z
  - 001 → !z
  - 100 → n^v
  - 101 → !(n^v)
  - 110 → c (unsigned borrow from the ALU subtraction)
  - 111 → !c
  - 010, 011 → 0
- Accept: in_valid & in_ready.
- Drain: out_valid & out_ready.
- Latency: an entry accepted at edge k is presented at out_* after edge k, i.e. 1 cycle.
- Storage: main register drives out_*; skid register holds one overflow entry.
  - Accept with main empty, or main draining and skid empty: entry loads main.
  - Accept while main holds and does not drain: entry loads skid, and in_ready falls next cycle.
  - Drain with skid full: skid moves to main and skid_valid clears. Simultaneous accept is impossible because in_ready=0.
  - Drain with skid empty and no accept: main_valid clears.
  - Ordering is strict FIFO; no entry is dropped or duplicated.
- out_* remain stable while out_valid=1 and out_ready=0.
- flush=1 at an edge:
  - main_valid and skid_valid clear.
  - A same-cycle accept is discarded.
  - A same-cycle drain still completes downstream.
  - flush has priority over every other update. Data registers may keep stale values.
- Control-output gating: out_reg_write, out_mem_read, out_mem_write and out_taken are forced to 0 whenever out_valid=0.
- Reset asserted mid-operation: all entries are discarded immediately; no partial state survives.

Optional Feature:
- Macro: EX_MEM_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt (32 bits).
  - Counts cycles with out_valid & !out_ready.
  - Saturates at 32'hFFFF_FFFF.
  - Clears on reset; not cleared by flush.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rstn=0 mid-cycle with stale entries → out_valid=0, in_ready=1, out_taken=0 immediately, without waiting for a clock edge.
- Single pass: accept alu_result=32'h0000_0010, rd=5, reg_write=1, out_ready=1 → next cycle out_valid=1, out_result=32'h10, out_rd=5, out_reg_write=1.
- Branch decode, each with branch=1:
  - funct3=000, status=4'b0100 → out_taken=1.
  - funct3=100, status=4'b1000 → out_taken=1.
  - funct3=110, status=4'b0000 → out_taken=0.
  - funct3=010 → out_taken=0.
- Backpressure: out_ready=0, three back-to-back in_valid with results 1, 2, 3:
  - Results 1 and 2 are accepted; in_ready=0 after the second.
  - out_result holds 1 until out_ready=1, then outputs 1, then 2.
  - Result 3 is accepted once in_ready returns.
- Flush: with main and skid full, pulse flush together with in_valid → next cycle out_valid=0, in_ready=1, and the flushed input never appears.
- With EX_MEM_STALL_CNT_EN: out_valid=1, out_ready=0 for 7 cycles → stall_cnt=7; flush does not clear it.
